// File: rtl/io_port_pkg.sv
// Shared definitions for the memory-mapped I/O port bank.
// Holds the STATUS register bit layout, the register-kind select
// decoded from address offset bit 0, and a ceiling-log2 helper
// used to size FIFO pointers and counts.
package io_port_pkg;

    localparam int ST_IN_VALID = 0;
    localparam int ST_IN_OVR   = 1;
    localparam int ST_OUT_DROP = 2;
    localparam int ST_OUT_FULL = 3;

    // Even offsets address a channel's DATA register, odd offsets its STATUS.
    typedef enum logic {
        REG_DATA   = 1'b0,
        REG_STATUS = 1'b1
    } reg_kind_t;

    // Smallest n such that 2**n >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_out_fifo.sv
// Single-channel output FIFO for the I/O port bank.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push, push_data   write request from the bus side
//   ready             consumer accepts the head word this cycle
//   clear_drop        clears the sticky drop flag
//   head              current head word (0 while empty)
//   valid             FIFO holds at least one word
//   full              FIFO holds DEPTH words
//   drop              sticky: a push was refused because the FIFO was full
module io_out_fifo
    import io_port_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              ready,
    input  logic              clear_drop,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic              full,
    output logic              drop
);

    localparam int             PTR_W      = clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] ONE_PTR  = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              do_pop;
    logic              do_push;

    // A pop in the same cycle frees a slot, so a push into a full FIFO
    // is still accepted when the consumer takes the head simultaneously.
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign valid   = !empty;
    assign head    = empty ? '0 : mem[rd_ptr];
    assign do_pop  = ready && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally at DEPTH; the explicit count disambiguates
    // full from empty when the pointers coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + ONE_COUNT;
                2'b01:   count <= count - ONE_COUNT;
                default: count <= count;
            endcase
            if (clear_drop) begin
                drop <= 1'b0;
            end
            if (push && !do_push) begin
                drop <= 1'b1;
            end
        end
    end

    // Storage needs no reset: head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/io_port_bank.sv
// Parametrised memory-mapped I/O bank on the datapath memory bus.
// Window of 2*CHANNELS words at BASE_ADDR: even offset = DATA k,
// odd offset = STATUS k. Each channel has a strobe-captured input
// register with sticky overrun and a buffered output FIFO.
// Ports:
//   CLK, reset           clock and synchronous active-high reset
//   memAddr              bus word address
//   memWriteData         bus write data
//   writeMem, readMem    bus write / read enables
//   hit                  memAddr lies inside the window (combinational)
//   rdData               registered read data, one cycle latency
//   ioInput, ioInStrobe  per-channel input words and capture pulses
//   ioOutput             per-channel output FIFO head
//   ioOutValid           per-channel FIFO non-empty
//   ioOutReady           per-channel consumer accept
module io_port_bank
    import io_port_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 16,
    parameter int                CHANNELS  = 4,
    parameter int                OUT_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 16'hFF00
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [ADDR_W-1:0]            memAddr,
    input  logic [DATA_W-1:0]            memWriteData,
    input  logic                         writeMem,
    input  logic                         readMem,
    output logic                         hit,
    output logic [DATA_W-1:0]            rdData,
    input  logic [CHANNELS*DATA_W-1:0]   ioInput,
    input  logic [CHANNELS-1:0]          ioInStrobe,
    output logic [CHANNELS*DATA_W-1:0]   ioOutput,
    output logic [CHANNELS-1:0]          ioOutValid,
    input  logic [CHANNELS-1:0]          ioOutReady
);

    localparam logic [ADDR_W-1:0] WINDOW_WORDS = ADDR_W'(2 * CHANNELS);

    logic [ADDR_W-1:0]   offset;
    logic [ADDR_W-1:0]   chan_sel;
    reg_kind_t           reg_kind;
    logic                bus_read;
    logic                bus_write;
    logic [CHANNELS-1:0] data_read;
    logic [CHANNELS-1:0] data_write;
    logic [CHANNELS-1:0] status_write;
    logic [CHANNELS-1:0] strobe_prev;
    logic [CHANNELS-1:0] in_valid;
    logic [CHANNELS-1:0] in_overrun;
    logic [CHANNELS-1:0] out_full;
    logic [CHANNELS-1:0] out_drop;
    logic [DATA_W-1:0]   in_data [CHANNELS];
    logic [DATA_W-1:0]   read_word;

    // Unsigned subtraction wraps addresses below BASE_ADDR to large
    // offsets, so a single compare rejects both sides of the window.
    assign offset    = memAddr - BASE_ADDR;
    assign hit       = (offset < WINDOW_WORDS);
    assign chan_sel  = offset >> 1;
    assign reg_kind  = reg_kind_t'(offset[0]);
    assign bus_read  = readMem && hit;
    assign bus_write = writeMem && hit;

    // One-hot per-channel access strobes from the decoded offset.
    always_comb begin
        data_read    = '0;
        data_write   = '0;
        status_write = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_sel == ADDR_W'(k)) begin
                data_read[k]    = bus_read && (reg_kind == REG_DATA);
                data_write[k]   = bus_write && (reg_kind == REG_DATA);
                status_write[k] = bus_write && (reg_kind == REG_STATUS);
            end
        end
    end

    // Input capture on strobe rising edges. A DATA read in the same cycle
    // as a capture consumes the old word, so the new one stays valid and
    // no overrun is flagged. A STATUS write clears overrun before any new
    // overrun from this cycle is applied.
    always_ff @(posedge CLK) begin
        if (reset) begin
            strobe_prev <= '0;
            in_valid    <= '0;
            in_overrun  <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                in_data[k] <= '0;
            end
        end else begin
            strobe_prev <= ioInStrobe;
            for (int k = 0; k < CHANNELS; k++) begin
                if (status_write[k]) begin
                    in_overrun[k] <= 1'b0;
                end
                if (ioInStrobe[k] && !strobe_prev[k]) begin
                    in_data[k]  <= ioInput[k*DATA_W +: DATA_W];
                    in_valid[k] <= 1'b1;
                    if (in_valid[k] && !data_read[k]) begin
                        in_overrun[k] <= 1'b1;
                    end
                end else if (data_read[k]) begin
                    in_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Read mux built from pre-edge state, so a simultaneous write or
    // capture is not visible in the returned word.
    always_comb begin
        read_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan_sel == ADDR_W'(k)) begin
                if (reg_kind == REG_DATA) begin
                    read_word = in_data[k];
                end else begin
                    read_word[ST_IN_VALID] = in_valid[k];
                    read_word[ST_IN_OVR]   = in_overrun[k];
                    read_word[ST_OUT_DROP] = out_drop[k];
                    read_word[ST_OUT_FULL] = out_full[k];
                end
            end
        end
    end

    // rdData only updates on an in-window read and otherwise holds.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rdData <= '0;
        end else if (bus_read) begin
            rdData <= read_word;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        io_out_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (OUT_DEPTH)
        ) u_fifo (
            .clk        (CLK),
            .reset      (reset),
            .push       (data_write[k]),
            .push_data  (memWriteData),
            .ready      (ioOutReady[k]),
            .clear_drop (status_write[k]),
            .head       (ioOutput[k*DATA_W +: DATA_W]),
            .valid      (ioOutValid[k]),
            .full       (out_full[k]),
            .drop       (out_drop[k])
        );
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank: directed scenarios plus a
// randomized run, all compared against a list-based behavioural model.
module tb_io_port_bank;

    localparam int          DATA_W    = 16;
    localparam int          ADDR_W    = 16;
    localparam int          CHANNELS  = 4;
    localparam int          OUT_DEPTH = 4;
    localparam logic [15:0] BASE      = 16'hFF00;

    logic                       CLK;
    logic                       reset;
    logic [ADDR_W-1:0]          memAddr;
    logic [DATA_W-1:0]          memWriteData;
    logic                       writeMem;
    logic                       readMem;
    logic                       hit;
    logic [DATA_W-1:0]          rdData;
    logic [CHANNELS*DATA_W-1:0] ioInput;
    logic [CHANNELS-1:0]        ioInStrobe;
    logic [CHANNELS*DATA_W-1:0] ioOutput;
    logic [CHANNELS-1:0]        ioOutValid;
    logic [CHANNELS-1:0]        ioOutReady;

    int n_tests;
    int n_fail;

    logic [15:0] m_in_data  [CHANNELS];
    bit          m_in_valid [CHANNELS];
    bit          m_in_ovr   [CHANNELS];
    bit          m_drop     [CHANNELS];
    logic [15:0] m_q        [CHANNELS][OUT_DEPTH];
    int          m_cnt      [CHANNELS];
    logic [3:0]  m_prev;
    logic [15:0] m_rd;

    io_port_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CHANNELS  (CHANNELS),
        .OUT_DEPTH (OUT_DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .memAddr      (memAddr),
        .memWriteData (memWriteData),
        .writeMem     (writeMem),
        .readMem      (readMem),
        .hit          (hit),
        .rdData       (rdData),
        .ioInput      (ioInput),
        .ioInStrobe   (ioInStrobe),
        .ioOutput     (ioOutput),
        .ioOutValid   (ioOutValid),
        .ioOutReady   (ioOutReady)
    );

    // 100 MHz free-running clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [15:0] m_status(input int ch);
        logic [15:0] s;
        s = 16'h0;
        s[0] = m_in_valid[ch];
        s[1] = m_in_ovr[ch];
        s[2] = m_drop[ch];
        s[3] = (m_cnt[ch] == OUT_DEPTH);
        return s;
    endfunction

    // Advance the reference model by one clock using the inputs currently
    // driven: reads see the old state, consumers take from the front of
    // each list before a new word is appended at the back.
    function automatic void model_step();
        int off;
        int ch;
        bit in_win;
        bit is_status;
        bit dr;
        if (reset) begin
            for (int k = 0; k < CHANNELS; k++) begin
                m_in_data[k]  = 16'h0;
                m_in_valid[k] = 1'b0;
                m_in_ovr[k]   = 1'b0;
                m_drop[k]     = 1'b0;
                m_cnt[k]      = 0;
            end
            m_prev = 4'h0;
            m_rd   = 16'h0;
            return;
        end
        off       = int'(memAddr) - int'(BASE);
        in_win    = (off >= 0) && (off < 2 * CHANNELS);
        ch        = in_win ? off / 2 : 0;
        is_status = in_win && (off % 2 == 1);
        if (readMem && in_win) begin
            m_rd = is_status ? m_status(ch) : m_in_data[ch];
        end
        for (int k = 0; k < CHANNELS; k++) begin
            if (ioOutReady[k] && m_cnt[k] > 0) begin
                for (int i = 0; i < OUT_DEPTH - 1; i++) begin
                    m_q[k][i] = m_q[k][i+1];
                end
                m_cnt[k] = m_cnt[k] - 1;
            end
        end
        if (writeMem && in_win) begin
            if (is_status) begin
                m_drop[ch]   = 1'b0;
                m_in_ovr[ch] = 1'b0;
            end else if (m_cnt[ch] < OUT_DEPTH) begin
                m_q[ch][m_cnt[ch]] = memWriteData;
                m_cnt[ch] = m_cnt[ch] + 1;
            end else begin
                m_drop[ch] = 1'b1;
            end
        end
        for (int k = 0; k < CHANNELS; k++) begin
            dr = readMem && in_win && !is_status && (ch == k);
            if (ioInStrobe[k] && !m_prev[k]) begin
                if (m_in_valid[k] && !dr) begin
                    m_in_ovr[k] = 1'b1;
                end
                m_in_data[k]  = ioInput[k*16 +: 16];
                m_in_valid[k] = 1'b1;
            end else if (dr) begin
                m_in_valid[k] = 1'b0;
            end
        end
        m_prev = ioInStrobe;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_read(input logic [15:0] addr);
        memAddr = addr;
        readMem = 1'b1;
        cycle();
        readMem = 1'b0;
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        memAddr      = addr;
        memWriteData = data;
        writeMem     = 1'b1;
        cycle();
        writeMem = 1'b0;
    endtask

    task automatic strobe(input int ch, input logic [15:0] value);
        ioInput[ch*16 +: 16] = value;
        ioInStrobe[ch]       = 1'b1;
        cycle();
        ioInStrobe[ch] = 1'b0;
        cycle();
    endtask

    task automatic test_reset();
        ioInput[15:0] = 16'hBEEF;
        ioInStrobe    = 4'b0001;
        bus_write(BASE, 16'h7777);
        ioInStrobe = 4'b0000;
        memAddr    = BASE;
        readMem    = 1'b1;
        reset      = 1'b1;
        cycle();
        cycle();
        reset   = 1'b0;
        readMem = 1'b0;
        n_tests++;
        if (rdData !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_rdData: got %h expected 0000", rdData);
        end
        n_tests++;
        if (ioOutValid !== 4'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outValid: got %b expected 0000", ioOutValid);
        end
        n_tests++;
        if (ioOutput !== 64'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_output: got %h expected 0", ioOutput);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            bus_read(BASE + 16'(2 * k + 1));
            n_tests++;
            if (rdData !== 16'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_status%0d: got %h expected 0000", k, rdData);
            end
        end
    endtask

    task automatic test_capture();
        strobe(2, 16'h1234);
        strobe(2, 16'h5678);
        bus_read(BASE + 16'd5);
        n_tests++;
        if (rdData !== 16'h0003) begin
            n_fail++;
            $display("[TB] FAIL overrun_status: got %h expected 0003", rdData);
        end
        bus_read(BASE + 16'd4);
        n_tests++;
        if (rdData !== 16'h5678) begin
            n_fail++;
            $display("[TB] FAIL overrun_data: got %h expected 5678", rdData);
        end
        bus_read(BASE + 16'd5);
        n_tests++;
        if (rdData !== 16'h0002) begin
            n_fail++;
            $display("[TB] FAIL after_read_status: got %h expected 0002", rdData);
        end
        bus_write(BASE + 16'd5, 16'hFFFF);
        bus_read(BASE + 16'd5);
        n_tests++;
        if (rdData !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL status_clear: got %h expected 0000", rdData);
        end
    endtask

    task automatic test_simultaneous();
        strobe(0, 16'h1111);
        ioInput[15:0] = 16'hAAAA;
        ioInStrobe[0] = 1'b1;
        memAddr       = BASE;
        readMem       = 1'b1;
        cycle();
        readMem       = 1'b0;
        ioInStrobe[0] = 1'b0;
        n_tests++;
        if (rdData !== 16'h1111) begin
            n_fail++;
            $display("[TB] FAIL simul_old_data: got %h expected 1111", rdData);
        end
        bus_read(BASE + 16'd1);
        n_tests++;
        if (rdData !== 16'h0001) begin
            n_fail++;
            $display("[TB] FAIL simul_status: got %h expected 0001", rdData);
        end
        bus_read(BASE);
        n_tests++;
        if (rdData !== 16'hAAAA) begin
            n_fail++;
            $display("[TB] FAIL simul_new_data: got %h expected aaaa", rdData);
        end
    endtask

    task automatic test_fifo_drop();
        ioOutReady = 4'b0000;
        for (int i = 1; i <= 5; i++) begin
            bus_write(BASE + 16'd2, 16'(i));
        end
        bus_read(BASE + 16'd3);
        n_tests++;
        if (rdData !== 16'h000C) begin
            n_fail++;
            $display("[TB] FAIL fifo_drop_status: got %h expected 000c", rdData);
        end
        ioOutReady[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_tests++;
            if (ioOutValid[1] !== 1'b1 || ioOutput[31:16] !== 16'(i)) begin
                n_fail++;
                $display("[TB] FAIL fifo_drain_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, ioOutValid[1], ioOutput[31:16], 16'(i));
            end
            cycle();
        end
        n_tests++;
        if (ioOutValid[1] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL fifo_empty: got valid=%b expected 0", ioOutValid[1]);
        end
        ioOutReady[1] = 1'b0;
        bus_write(BASE + 16'd3, 16'h0);
    endtask

    task automatic test_full_pop();
        for (int i = 0; i < 4; i++) begin
            bus_write(BASE + 16'd6, 16'h0301 + 16'(i));
        end
        ioOutReady[3] = 1'b1;
        bus_write(BASE + 16'd6, 16'h00FF);
        ioOutReady[3] = 1'b0;
        bus_read(BASE + 16'd7);
        n_tests++;
        if (rdData !== 16'h0008) begin
            n_fail++;
            $display("[TB] FAIL full_pop_status: got %h expected 0008", rdData);
        end
        ioOutReady[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] want;
            want = (i == 3) ? 16'h00FF : 16'h0302 + 16'(i);
            n_tests++;
            if (ioOutValid[3] !== 1'b1 || ioOutput[63:48] !== want) begin
                n_fail++;
                $display("[TB] FAIL full_pop_seq_%0d: got valid=%b data=%h expected valid=1 data=%h",
                         i, ioOutValid[3], ioOutput[63:48], want);
            end
            cycle();
        end
        n_tests++;
        if (ioOutValid[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_pop_empty: got valid=%b expected 0", ioOutValid[3]);
        end
        ioOutReady[3] = 1'b0;
    endtask

    task automatic test_window();
        logic [15:0] outside [2];
        outside[0] = BASE + 16'd8;
        outside[1] = BASE - 16'd1;
        strobe(1, 16'hC0DE);
        bus_read(BASE + 16'd2);
        for (int j = 0; j < 2; j++) begin
            memAddr      = outside[j];
            memWriteData = 16'h1234;
            readMem      = 1'b1;
            writeMem     = 1'b1;
            #1;
            n_tests++;
            if (hit !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL window_hit_%0d: got %b expected 0", j, hit);
            end
            cycle();
            readMem  = 1'b0;
            writeMem = 1'b0;
            n_tests++;
            if (rdData !== 16'hC0DE || ioOutValid !== 4'h0) begin
                n_fail++;
                $display("[TB] FAIL window_nochange_%0d: got rd=%h valid=%b expected rd=c0de valid=0000",
                         j, rdData, ioOutValid);
            end
        end
        memAddr = BASE;
        #1;
        n_tests++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL window_low_edge: got %b expected 1", hit);
        end
        memAddr = BASE + 16'd7;
        #1;
        n_tests++;
        if (hit !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL window_high_edge: got %b expected 1", hit);
        end
        bus_read(BASE + 16'd7);
        n_tests++;
        if (rdData !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL window_status3: got %h expected 0000", rdData);
        end
    endtask

    task automatic test_read_write_same();
        strobe(1, 16'h4242);
        strobe(1, 16'h4343);
        memAddr      = BASE + 16'd3;
        memWriteData = 16'h0000;
        readMem      = 1'b1;
        writeMem     = 1'b1;
        cycle();
        n_tests++;
        if (rdData !== 16'h0003) begin
            n_fail++;
            $display("[TB] FAIL rw_status_pre: got %h expected 0003", rdData);
        end
        memAddr      = BASE + 16'd2;
        memWriteData = 16'h9999;
        cycle();
        readMem  = 1'b0;
        writeMem = 1'b0;
        n_tests++;
        if (rdData !== 16'h4343 || ioOutValid[1] !== 1'b1 || ioOutput[31:16] !== 16'h9999) begin
            n_fail++;
            $display("[TB] FAIL rw_data: got rd=%h valid=%b out=%h expected rd=4343 valid=1 out=9999",
                     rdData, ioOutValid[1], ioOutput[31:16]);
        end
        bus_read(BASE + 16'd3);
        n_tests++;
        if (rdData !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL rw_status_post: got %h expected 0000", rdData);
        end
        ioOutReady[1] = 1'b1;
        cycle();
        ioOutReady[1] = 1'b0;
    endtask

    task automatic test_random();
        logic [CHANNELS-1:0]        exp_valid;
        logic [CHANNELS*DATA_W-1:0] exp_out;
        int                         off;
        bit                         exp_hit;
        for (int n = 0; n < 600; n++) begin
            reset        = ($urandom_range(0, 99) == 0);
            memAddr      = BASE - 16'd2 + 16'($urandom_range(0, 11));
            readMem      = ($urandom_range(0, 2) == 0);
            writeMem     = ($urandom_range(0, 3) == 0);
            memWriteData = 16'($urandom());
            ioInput      = {$urandom(), $urandom()};
            ioInStrobe   = 4'($urandom());
            ioOutReady   = 4'($urandom());
            #1;
            off     = int'(memAddr) - int'(BASE);
            exp_hit = (off >= 0) && (off < 2 * CHANNELS);
            n_tests++;
            if (hit !== exp_hit) begin
                n_fail++;
                $display("[TB] FAIL rand_hit @%0d addr=%h: got %b expected %b", n, memAddr, hit, exp_hit);
            end
            cycle();
            for (int k = 0; k < CHANNELS; k++) begin
                exp_valid[k]         = (m_cnt[k] > 0);
                exp_out[k*16 +: 16]  = (m_cnt[k] > 0) ? m_q[k][0] : 16'h0;
            end
            n_tests++;
            if (rdData !== m_rd) begin
                n_fail++;
                $display("[TB] FAIL rand_rdData @%0d: got %h expected %h", n, rdData, m_rd);
            end
            n_tests++;
            if (ioOutValid !== exp_valid || ioOutput !== exp_out) begin
                n_fail++;
                $display("[TB] FAIL rand_out @%0d: got valid=%b out=%h expected valid=%b out=%h",
                         n, ioOutValid, ioOutput, exp_valid, exp_out);
            end
        end
        reset      = 1'b0;
        readMem    = 1'b0;
        writeMem   = 1'b0;
        ioInStrobe = 4'h0;
        ioOutReady = 4'h0;
        cycle();
    endtask

    // Drive a clean reset, then run every scenario in order.
    initial begin
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        memAddr      = 16'h0;
        memWriteData = 16'h0;
        writeMem     = 1'b0;
        readMem      = 1'b0;
        ioInput      = '0;
        ioInStrobe   = '0;
        ioOutReady   = '0;
        @(posedge CLK);
        #1;
        cycle();
        cycle();
        reset = 1'b0;
        test_reset();
        test_capture();
        test_simultaneous();
        test_fifo_drop();
        test_full_pop();
        test_window();
        test_read_write_same();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised memory-mapped I/O bank that replaces the single fixed 16-bit ioInput/ioOutput pair on the processor top level. It sits on the datapath memory bus beside main memory. It decodes a small address window and gives CHANNELS independent channels. Each channel has a strobe-captured input register with sticky overrun detection and a buffered output FIFO with a valid/ready handshake toward the pins.

## Interface
- DATA_W, 16, width of every data word and of each channel.
- ADDR_W, 16, memory bus address width.
- CHANNELS, 4, number of I/O channels (1..8).
- OUT_DEPTH, 4, output FIFO depth per channel (power of two, ≥2).
- BASE_ADDR, 16'hFF00, first word address of the window; window size 2*CHANNELS words.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- memAddr  in  ADDR_W  bus word address.
- memWriteData  in  DATA_W  bus write data.
- writeMem  in  1  bus write enable.
- readMem  in  1  bus read enable.
- hit  out  1  combinational: memAddr inside window.
- rdData  out  DATA_W  registered read data.
- ioInput  in  CHANNELS*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
- ioInStrobe  in  CHANNELS  per-channel capture pulse, synchronous to CLK.
- ioOutput  out  CHANNELS*DATA_W  FIFO head per channel.
- ioOutValid  out  CHANNELS  FIFO non-empty.
- ioOutReady  in  CHANNELS  consumer accepts head.

## Operation
- Offset = memAddr − BASE_ADDR. hit = 1 when offset < 2*CHANNELS. Accesses without hit are ignored and leave rdData unchanged.
- Offset 2k, DATA k:
  - Write pushes memWriteData into out-FIFO k.
  - Read returns the in-capture k value and clears inValid k.
- Offset 2k+1, STATUS k:
  - Read returns {…0, outFull, outDrop, inOverrun, inValid} in bits [3:0].
  - Write of any value clears inOverrun and outDrop.
- Input capture, per channel:
  - A rising edge of ioInStrobe[k] (0 in the previous cycle, 1 now) loads ioInput slice k and sets inValid.
  - If inValid is already 1 and no DATA read happens in the same cycle, inOverrun is set (sticky) and the data is overwritten.
  - Capture and DATA read in the same cycle: the new data is loaded, inValid stays 1, no overrun. rdData returns the old value.
- Output FIFO, per channel:
  - A transfer happens when ioOutValid & ioOutReady; the head advances.
  - A push when full is dropped and outDrop is set (sticky). Exception: a pop in the same cycle frees a slot, so the push is accepted.
  - Simultaneous push and pop on a non-empty FIFO leaves the count unchanged.
  - Pointers are log2(OUT_DEPTH) bits and wrap modulo OUT_DEPTH. An explicit count of log2(OUT_DEPTH)+1 bits drives full and empty.
- readMem and writeMem asserted together at the same address: the write takes effect, and the read returns the pre-write state.
- reset clears every capture register, flag, FIFO pointer and count, rdData and the strobe-edge history. A reset during any access discards that access.

## Timing
- Reset values: rdData = 0, ioOutput = 0, ioOutValid = 0, hit follows memAddr.
- Read latency is 1 cycle. rdData is valid on the cycle after readMem & hit, and holds until the next hit read. Side effects of a read happen at the same edge.
- Write to DATA k: ioOutValid[k] rises on the next cycle when the FIFO was empty. ioOutput[k] is combinational from the FIFO head.
- Strobe to capture: inValid is visible in STATUS on reads issued from the cycle after the strobe edge.
- Channels are fully independent; accesses to different channels in the same cycle cannot happen (single bus).

## Structure
- Package io_port_pkg holds:
  - the status bit positions (ST_IN_VALID = 0, ST_IN_OVR = 1, ST_OUT_DROP = 2, ST_OUT_FULL = 3);
  - the register-kind select (REG_DATA = 0, REG_STATUS = 1, taken from offset bit 0);
  - a clog2 helper function.
- Sub-module io_out_fifo (params DATA_W, DEPTH): a single-channel FIFO with push/pop, full/empty/count and drop detection. It is instantiated CHANNELS times in a generate loop.
- Input capture, address decode and the read mux live in io_port_bank.

## Test plan
- Reset: hold reset 2 cycles mid-transaction, then release → rdData = 0, ioOutValid = 0, every STATUS reads 0.
- Input capture/overrun: strobe channel 2 with 16'h1234, then 16'h5678 before any read → STATUS 2 = 4'b0011, DATA 2 = 16'h5678, then STATUS 2 = 4'b0010. Write STATUS 2 → reads 0.
- Simultaneous strobe and read: strobe channel 0 with 16'hAAAA and read DATA 0 in the same cycle while holding 16'h1111 → rdData = 16'h1111, inValid = 1, inOverrun = 0.
- Output FIFO fill/drop: ioOutReady[1] = 0, write 5 words (1..5) to DATA 1 with OUT_DEPTH = 4 → STATUS 1 = 4'b1100. Raise ready → ioOutput 1 sequence is 1, 2, 3, 4, then ioOutValid drops.
- Full with simultaneous pop: FIFO 3 full, ready = 1 and a write of 16'h00FF in the same cycle → accepted, no outDrop, 16'h00FF emerges last.
- Window decode: access BASE_ADDR+2*CHANNELS and BASE_ADDR−1 → hit = 0, no state change, rdData unchanged.
